apb_master_arbiter: RTL and testbench
=====================================

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameter ADDR_LO, default apb_pkg::APB_START_ADDRESS, lowest address forwarded to the bus.
REQ-002 Parameter ADDR_HI, default apb_pkg::APB_END_ADDRESS, highest address forwarded to the bus.
REQ-003 Parameter MAX_WAIT, default apb_pkg::APB_MAX_WAIT_STATES, number of wait states tolerated before timeout.
REQ-004 Ports; one clock; reset is synchronous and active-high:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reqN_valid  in  1  request from requester N (N = 0, 1)
- reqN_write  in  1  1 = write, 0 = read
- reqN_addr  in  32  address
- reqN_wdata  in  32  write data
- reqN_ready  out  1  request accepted this cycle
- rspN_valid  out  1  one-cycle response pulse
- rspN_rdata  out  32  read data
- rspN_err  out  1  error flag
- psel_out, penable_out, pwrite_out  out  1  APB control
- paddr_out, pwdata_out  out  32  APB address/data
- prdata_in  in  32  APB read data
- pready_in, pslverr_in  in  1  APB slave response

Function
REQ-005 FSM states: IDLE, SETUP, ACCESS, RESP.
REQ-006 IDLE: reqN_ready is combinational; it is 1 only for the arbitration winner while that requester's reqN_valid=1.
REQ-007 Arbitration is 2-way round-robin: with a single request, that requester wins; with both, the requester not granted last wins; last_grant resets to 1, so req0 wins first.
REQ-008 On accept, command, address and wdata are latched; the address is in range when ADDR_LO <= addr <= ADDR_HI.
REQ-009 In-range accept: IDLE->SETUP; SETUP drives psel=1, penable=0 and the latched command for exactly 1 cycle, then ACCESS.
REQ-010 ACCESS: psel=1, penable=1; on pready_in=1 the block captures prdata_in (reads only, 0 for writes) and pslverr_in, then goes to RESP.
REQ-011 Out-of-range accept: IDLE->RESP directly, no bus activity, err=1, rdata=0.
REQ-012 RESP: the granted requester's rspN_valid=1 for exactly 1 cycle with the captured rdata/err, then IDLE. There is no response back-pressure.
REQ-013 The other requester's rsp outputs stay 0. rspN_rdata/err are 0 whenever rspN_valid=0.
REQ-014 Latency, in-range with zero wait states: accept cycle T, SETUP T+1, ACCESS T+2, rsp_valid T+3. The next accept is possible no earlier than T+4.
REQ-015 reqN inputs are ignored outside IDLE.
REQ-016 psel/penable/paddr/pwrite/pwdata remain stable from SETUP through the end of ACCESS; all are 0 in IDLE and RESP.

Reset
REQ-017 A synchronous reset forces IDLE, last_grant=1 and wait counter=0, and drives all outputs to 0 on the next edge.
REQ-018 Reset mid-transfer (SETUP/ACCESS/RESP) aborts the transfer, and no response is delivered.

Configuration
REQ-019 Macro APB_ARB_TIMEOUT_EN defined: in ACCESS a counter counts cycles with pready_in=0. When pready_in=0 and count==MAX_WAIT, the transfer is terminated and the block goes to RESP with err=1, rdata=0; psel/penable drop to 0.
REQ-020 Macro APB_ARB_TIMEOUT_EN undefined: no counter is built, and ACCESS waits indefinitely for pready_in.

Structure
REQ-021 The FSM state enum typedef apb_arb_state_t is added to apb_pkg; address limits and wait limit come from apb_pkg constants.
REQ-022 The round-robin decision is a separate sub-module apb_rr_arbiter: inputs valid[1:0], last_grant, enable; output grant[1:0], one-hot or zero.

Verification
REQ-023 req0 write addr 8C000000 data 12345678, pready=1 -> psel at T+1, penable at T+2, rsp0_valid at T+3 with err=0.
REQ-024 req1 read addr 8C000000, prdata=CAFEF00D, pslverr=1 -> rsp1_valid with rdata=CAFEF00D, err=1.
REQ-025 Both valid continuously for 4 transfers after reset -> grant order 0,1,0,1, with no overlap of psel phases.
REQ-026 req0 addr 8C000004 -> psel stays 0, rsp0_valid one cycle after accept, err=1, rdata=0.
REQ-027 APB_ARB_TIMEOUT_EN defined, MAX_WAIT=0, pready held 0 -> rsp_valid err=1 one cycle after the first ACCESS cycle. Macro undefined -> block stays in ACCESS for 100 cycles, then completes when pready rises.
REQ-028 rst asserted during ACCESS -> all outputs 0 next cycle, no rsp_valid, and the next request is accepted normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB constants, the arbiter FSM state type and the address-window helper
// used by apb_master_arbiter and its testbench.
package apb_pkg;

  localparam logic [31:0] APB_START_ADDRESS   = 32'h8C00_0000;
  localparam logic [31:0] APB_END_ADDRESS     = 32'h8C00_0003;
  localparam int unsigned APB_MAX_WAIT_STATES = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_arb_state_t;

  function automatic logic addrInRange(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not granted last. Grant is one-hot or zero.
module apb_rr_arbiter (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master with round-robin arbitration and address-window check.
// Define APB_ARB_TIMEOUT_EN to build the ACCESS wait-state timeout counter.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter logic [31:0] ADDR_LO  = apb_pkg::APB_START_ADDRESS,
  parameter logic [31:0] ADDR_HI  = apb_pkg::APB_END_ADDRESS,
  parameter int unsigned MAX_WAIT = apb_pkg::APB_MAX_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        psel_out,
  output logic        penable_out,
  output logic        pwrite_out,
  output logic [31:0] paddr_out,
  output logic [31:0] pwdata_out,
  input  logic [31:0] prdata_in,
  input  logic        pready_in,
  input  logic        pslverr_in
);

  apb_arb_state_t state_q;
  logic           lastGrant_q;
  logic           owner_q;
  logic           psel_q;
  logic           penable_q;
  logic           pwrite_q;
  logic [31:0]    paddr_q;
  logic [31:0]    pwdata_q;
  logic [1:0]     rspValid_q;
  logic [31:0]    rspRdata_q;
  logic           rspErr_q;
`ifdef APB_ARB_TIMEOUT_EN
  logic [31:0]    waitCnt_q;
`endif

  logic [1:0]  grant;
  logic        selWrite;
  logic [31:0] selAddr;
  logic [31:0] selWdata;

  if (MAX_WAIT > 32'd65535) begin : gMaxWaitCheck
    $error("apb_master_arbiter: MAX_WAIT must not exceed 65535");
  end

  apb_rr_arbiter uArb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (lastGrant_q),
    .enable     ((state_q == IDLE) && !rst),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign selWrite = grant[1] ? req1_write : req0_write;
  assign selAddr  = grant[1] ? req1_addr  : req0_addr;
  assign selWdata = grant[1] ? req1_wdata : req0_wdata;

  assign psel_out    = psel_q;
  assign penable_out = penable_q;
  assign pwrite_out  = pwrite_q;
  assign paddr_out   = paddr_q;
  assign pwdata_out  = pwdata_q;

  // Response data is shared; gating keeps the idle requester's outputs at zero.
  assign rsp0_valid = rspValid_q[0];
  assign rsp1_valid = rspValid_q[1];
  assign rsp0_rdata = rspValid_q[0] ? rspRdata_q : 32'h0;
  assign rsp1_rdata = rspValid_q[1] ? rspRdata_q : 32'h0;
  assign rsp0_err   = rspValid_q[0] & rspErr_q;
  assign rsp1_err   = rspValid_q[1] & rspErr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'h0;
      pwdata_q    <= 32'h0;
      rspValid_q  <= 2'b00;
      rspRdata_q  <= 32'h0;
      rspErr_q    <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      waitCnt_q   <= 32'h0;
`endif
    end else begin
      rspValid_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (grant != 2'b00) begin
            owner_q     <= grant[1];
            lastGrant_q <= grant[1];
            if (addrInRange(selAddr, ADDR_LO, ADDR_HI)) begin
              state_q  <= SETUP;
              psel_q   <= 1'b1;
              pwrite_q <= selWrite;
              paddr_q  <= selAddr;
              pwdata_q <= selWdata;
            end else begin
              // Out-of-window requests never touch the bus and answer with an error.
              state_q    <= RESP;
              rspValid_q <= grant;
              rspRdata_q <= 32'h0;
              rspErr_q   <= 1'b1;
            end
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          waitCnt_q <= 32'h0;
`endif
        end
        ACCESS: begin
          if (pready_in) begin
            state_q    <= RESP;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= 32'h0;
            pwdata_q   <= 32'h0;
            rspValid_q <= owner_q ? 2'b10 : 2'b01;
            rspRdata_q <= pwrite_q ? 32'h0 : prdata_in;
            rspErr_q   <= pslverr_in;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (waitCnt_q == MAX_WAIT) begin
            state_q    <= RESP;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= 32'h0;
            pwdata_q   <= 32'h0;
            rspValid_q <= owner_q ? 2'b10 : 2'b01;
            rspRdata_q <= 32'h0;
            rspErr_q   <= 1'b1;
          end else begin
            waitCnt_q <= waitCnt_q + 32'd1;
          end
`endif
        end
        RESP: begin
          state_q    <= IDLE;
          rspRdata_q <= 32'h0;
          rspErr_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: a stimulus process predicts grants and
// responses, an APB slave model answers the bus, and a monitor checks every response.
module tb_apb_master_arbiter;
  import apb_pkg::*;

  localparam logic [31:0] LO   = APB_START_ADDRESS;
  localparam logic [31:0] HI   = APB_END_ADDRESS;
  localparam int          MAXW = APB_MAX_WAIT_STATES;
`ifdef APB_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        psel_out, penable_out, pwrite_out;
  logic [31:0] paddr_out, pwdata_out;
  logic [31:0] prdata_in = '0;
  logic        pready_in = 1'b0, pslverr_in = 1'b0;

  apb_master_arbiter #(.ADDR_LO(LO), .ADDR_HI(HI), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .psel_out(psel_out), .penable_out(penable_out), .pwrite_out(pwrite_out),
    .paddr_out(paddr_out), .pwdata_out(pwdata_out),
    .prdata_in(prdata_in), .pready_in(pready_in), .pslverr_in(pslverr_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          req;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acceptCycle;
  } cmd_t;

  typedef struct {
    int          req;
    logic [31:0] rdata;
    logic        err;
    int          expCycle;
  } rsp_t;

  cmd_t busQ[$];
  rsp_t rspQ[$];
  int   rspLog[$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int freeCycle = 0;
  bit busy = 1'b0;
  int lastGrant = 1;

  int          forceWaits = -1;
  bit          forceResp = 1'b0;
  logic [31:0] forcedRdata = '0;
  logic        forcedErr = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input int req, input logic write,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (req == 0) begin
      req0_valid = 1'b1; req0_write = write; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = 1'b1; req1_write = write; req1_addr = addr; req1_wdata = wdata;
    end
  endtask

  function automatic int modelWinner(input logic v0, input logic v1);
    if (v0 && v1) return (lastGrant == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic bit inWindow(input logic [31:0] a);
    return (a >= LO) && (a <= HI);
  endfunction

  function automatic logic [31:0] randAddr();
    return LO - 32'd2 + 32'($urandom_range(0, 7));
  endfunction

  task automatic modelAccept(input int win);
    cmd_t c;
    c.req         = win;
    c.write       = (win == 0) ? req0_write : req1_write;
    c.addr        = (win == 0) ? req0_addr  : req1_addr;
    c.wdata       = (win == 0) ? req0_wdata : req1_wdata;
    c.acceptCycle = cycle;
    lastGrant = win;
    busy = 1'b1;
    if (inWindow(c.addr)) busQ.push_back(c);
    else rspQ.push_back('{win, 32'h0, 1'b1, cycle + 1});
  endtask

  // One cycle: predict and check the handshake, then advance to just past the edge.
  task automatic tick(input bit autoGen);
    int win;
    logic [1:0] expReady;
    @(negedge clk); #1;
    win = (!busy && cycle >= freeCycle && !rst) ? modelWinner(req0_valid, req1_valid) : -1;
    expReady = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
    checkOutput("req_ready", {req1_ready, req0_ready}, expReady);
    if (win >= 0) modelAccept(win);
    @(posedge clk); #1;
    if (win == 0) req0_valid = 1'b0;
    if (win == 1) req1_valid = 1'b0;
    if (autoGen) begin
      if (!req0_valid && $urandom_range(0, 2) == 0)
        applyStimulus(0, 1'($urandom_range(0, 1)), randAddr(), $urandom());
      if (!req1_valid && $urandom_range(0, 2) == 0)
        applyStimulus(1, 1'($urandom_range(0, 1)), randAddr(), $urandom());
    end
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((busy || cycle < freeCycle || req0_valid || req1_valid) && n < budget) begin
      tick(1'b0);
      n++;
    end
    if (n >= budget) checkOutput("drain_timeout", {busy, req0_valid, req1_valid}, 3'b000);
  endtask

  task automatic doReset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    busQ.delete();
    rspQ.delete();
    busy = 1'b0;
    freeCycle = 0;
    lastGrant = 1;
    @(negedge clk);
    checkOutput("reset_bus_ctrl", {psel_out, penable_out, pwrite_out}, 3'b000);
    checkOutput("reset_paddr", paddr_out, 32'h0);
    checkOutput("reset_pwdata", pwdata_out, 32'h0);
    checkOutput("reset_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
    checkOutput("reset_rsp_data", {rsp1_err, rsp1_rdata, rsp0_err, rsp0_rdata}, '0);
    checkOutput("reset_ready", {req1_ready, req0_ready}, 2'b00);
    @(posedge clk); #1;
  endtask

  // APB slave model: checks the command on the bus and predicts the response.
  cmd_t        cur;
  bit          active = 1'b0;
  int          remaining = 0;
  int          waits;
  logic [31:0] chosenRdata;
  logic        chosenErr;

  always begin
    @(posedge clk); #1;
    if (psel_out && !penable_out) begin
      if (busQ.size() == 0) begin
        checkOutput("unexpected_setup", psel_out, 1'b0);
      end else begin
        cur = busQ.pop_front();
        checkOutput("setup_cycle", cycle, cur.acceptCycle + 1);
        checkOutput("setup_paddr", paddr_out, cur.addr);
        checkOutput("setup_pwrite", pwrite_out, cur.write);
        checkOutput("setup_pwdata", pwdata_out, cur.wdata);
        waits = (forceWaits >= 0) ? forceWaits : $urandom_range(0, 3);
        chosenRdata = forceResp ? forcedRdata : $urandom();
        chosenErr = forceResp ? forcedErr : ($urandom_range(0, 3) == 0);
        if (TIMEOUT_EN && waits > MAXW)
          rspQ.push_back('{cur.req, 32'h0, 1'b1, cur.acceptCycle + 3 + MAXW});
        else
          rspQ.push_back('{cur.req, cur.write ? 32'h0 : chosenRdata, chosenErr,
                           cur.acceptCycle + 3 + waits});
        remaining = waits;
        active = 1'b1;
      end
      pready_in = 1'b0;
      prdata_in = $urandom();
      pslverr_in = 1'($urandom_range(0, 1));
    end else if (psel_out && penable_out) begin
      if (!active) begin
        checkOutput("access_without_setup", penable_out, 1'b0);
      end else begin
        checkOutput("access_paddr", paddr_out, cur.addr);
        checkOutput("access_pwrite", pwrite_out, cur.write);
        checkOutput("access_pwdata", pwdata_out, cur.wdata);
      end
      if (remaining == 0) begin
        pready_in = 1'b1;
        prdata_in = chosenRdata;
        pslverr_in = chosenErr;
      end else begin
        pready_in = 1'b0;
        prdata_in = $urandom();
        pslverr_in = 1'($urandom_range(0, 1));
        remaining--;
      end
    end else begin
      active = 1'b0;
      pready_in = 1'b0;
      prdata_in = $urandom();
      pslverr_in = 1'($urandom_range(0, 1));
      checkOutput("idle_bus", {penable_out, pwrite_out, paddr_out, pwdata_out}, '0);
    end
  end

  // Monitor: pops the scoreboard whenever a response pulse appears.
  rsp_t expRsp;
  int   who;

  always @(negedge clk) begin
    if (!rsp0_valid) checkOutput("rsp0_quiet", {rsp0_err, rsp0_rdata}, '0);
    if (!rsp1_valid) checkOutput("rsp1_quiet", {rsp1_err, rsp1_rdata}, '0);
    if (rsp0_valid || rsp1_valid) begin
      checkOutput("rsp_onehot", {rsp1_valid, rsp0_valid} == 2'b11, 1'b0);
      who = rsp1_valid ? 1 : 0;
      rspLog.push_back(who);
      if (rspQ.size() == 0) begin
        checkOutput("unexpected_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
      end else begin
        expRsp = rspQ.pop_front();
        checkOutput("rsp_requester", who, expRsp.req);
        checkOutput("rsp_rdata", (who == 1) ? rsp1_rdata : rsp0_rdata, expRsp.rdata);
        checkOutput("rsp_err", (who == 1) ? rsp1_err : rsp0_err, expRsp.err);
        checkOutput("rsp_cycle", cycle, expRsp.expCycle);
      end
      busy = 1'b0;
      freeCycle = cycle + 1;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(posedge clk); #1;
    doReset();

    // Zero-wait write from req0 with an OKAY response.
    forceResp = 1'b1; forcedRdata = 32'hDEAD_BEEF; forcedErr = 1'b0; forceWaits = 0;
    applyStimulus(0, 1'b1, 32'h8C00_0000, 32'h1234_5678);
    waitIdle(20);

    // Read from req1 with a slave error.
    forcedRdata = 32'hCAFE_F00D; forcedErr = 1'b1;
    applyStimulus(1, 1'b0, 32'h8C00_0000, 32'h0);
    waitIdle(20);

    // Window edges: just past the top, top itself, just below the bottom.
    forceResp = 1'b0; forceWaits = -1;
    applyStimulus(0, 1'b0, 32'h8C00_0004, 32'h0);
    waitIdle(20);
    applyStimulus(1, 1'b0, HI, 32'h0);
    waitIdle(20);
    applyStimulus(0, 1'b1, LO - 32'd1, 32'h5555_AAAA);
    waitIdle(20);

    // Both requesters held valid after reset must alternate starting with req0.
    doReset();
    rspLog.delete();
    for (int k = 0; k < 60 && rspLog.size() < 4; k++) begin
      if (!req0_valid) applyStimulus(0, 1'b0, LO, 32'h0);
      if (!req1_valid) applyStimulus(1, 1'b1, HI, 32'hA5A5_0000 + 32'(k));
      tick(1'b0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checkOutput("rr_count", rspLog.size() >= 4, 1'b1);
    for (int i = 0; i < 4 && i < rspLog.size(); i++)
      checkOutput("rr_order", rspLog[i], i % 2);
    waitIdle(20);

    // Long stall: completes after 100 wait states, or times out when enabled.
    forceWaits = 100;
    applyStimulus(0, 1'b0, LO + 32'd1, 32'h0);
    waitIdle(300);

    // Reset in the middle of ACCESS, then a normal transfer.
    forceWaits = 50;
    applyStimulus(1, 1'b0, LO + 32'd2, 32'h0);
    for (int k = 0; k < 10 && req1_valid; k++) tick(1'b0);
    tick(1'b0);
    doReset();
    forceWaits = -1;
    applyStimulus(1, 1'b1, LO + 32'd3, 32'h0BAD_CAFE);
    waitIdle(20);

    // Random traffic from both requesters.
    for (int k = 0; k < 400; k++) tick(1'b1);
    waitIdle(200);
    checkOutput("leftover_rsp", rspQ.size(), 0);
    checkOutput("leftover_cmd", busQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
